// File: rtl/memory_bank.sv
`default_nettype none
// ============================================================================
//  Module      : memory_bank
//  Description : DEPTH x WIDTH storage with one save-enabled write port, two
//                independent registered (write-first) read ports and a
//                sequenced bulk-clear engine that sweeps CLEAR_VALUE through
//                every entry, one entry per cycle.
//  Ports       : clk        - clock, all state changes on rising edge
//                rst_n      - asynchronous active-low reset
//                save       - write enable
//                waddr      - write address (AW bits)
//                value      - write data (WIDTH bits)
//                raddr_a/b  - read addresses, ports A/B
//                out_a/b    - registered read data, ports A/B
//                clear      - bulk-clear request (level, sampled when idle)
//                busy       - high while the clear sweep runs
//                save_drop  - save requested but discarded this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_bank #(
    parameter int                 WIDTH       = 8,
    parameter int                 DEPTH       = 8,
    parameter logic [WIDTH-1:0]   INIT_VALUE  = '0,
    parameter logic [WIDTH-1:0]   CLEAR_VALUE = '0,
    localparam int                AW          = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             save,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] value,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] out_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] out_b,
    input  logic             clear,
    output logic             busy,
    output logic             save_drop
);

    localparam logic [0:0]    c_S_IDLE  = 1'b0;
    localparam logic [0:0]    c_S_CLEAR = 1'b1;
    localparam logic [AW-1:0] c_LAST    = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_ONE     = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [0:0]       r_state;
    logic [AW-1:0]    r_ptr;
    logic             r_busy;
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;

    logic             w_waddr_ok;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_next [DEPTH];
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // Address range check is done at 32 bits so a non-power-of-two DEPTH
    // (where AW bits can encode addresses past the last entry) is handled.
    assign w_waddr_ok = (32'(waddr) < 32'(DEPTH));
    assign w_wr_en    = save & ~r_busy & w_waddr_ok;
    assign save_drop  = save & (r_busy | ~w_waddr_ok);

    // Contents every entry will hold after this edge. The user write and the
    // sweep write are mutually exclusive because writes are blocked while busy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_next[i] = r_mem[i];
            if (r_busy && (32'(r_ptr) == 32'(i))) begin
                w_next[i] = CLEAR_VALUE;
            end
            if (w_wr_en && (32'(waddr) == 32'(i))) begin
                w_next[i] = value;
            end
        end
    end

    // Read muxes select from the post-edge contents (write-first). An address
    // that matches no entry leaves the default of zero.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (32'(raddr_a) == 32'(i)) begin
                w_rd_a = w_next[i];
            end
            if (32'(raddr_b) == 32'(i)) begin
                w_rd_b = w_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= INIT_VALUE;
            end
            r_out_a <= '0;
            r_out_b <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= w_next[i];
            end
            r_out_a <= w_rd_a;
            r_out_b <= w_rd_b;
        end
    end

    // Clear sequencer. busy is registered alongside the state so it is
    // high for exactly DEPTH cycles per sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (clear) begin
                        r_state <= c_S_CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                c_S_CLEAR: begin
                    if (r_ptr == c_LAST) begin
                        // clear is not re-sampled here; it must be seen in IDLE.
                        r_state <= c_S_IDLE;
                        r_ptr   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr   <= r_ptr + c_ONE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_ptr   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_a = r_out_a;
    assign out_b = r_out_b;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_memory_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_bank
//  Description : Self-checking bench for memory_bank. Two instances share one
//                stimulus: the default 8-entry build and a 6-entry build with
//                distinct init/clear words, so out-of-range addresses and the
//                sweep order are observable. A behavioural model of both is
//                compared against the DUT outputs every cycle, and directed
//                scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_bank;

    logic       clk;
    logic       rst_n;
    logic       save;
    logic [2:0] waddr;
    logic [7:0] value;
    logic [2:0] raddr_a;
    logic [2:0] raddr_b;
    logic       clear;

    logic [7:0] out_a0, out_b0, out_a1, out_b1;
    logic       busy0, busy1, drop0, drop1;

    int errors   = 0;
    int n_checks = 0;
    bit checking = 1'b0;

    memory_bank u0 (
        .clk(clk), .rst_n(rst_n), .save(save), .waddr(waddr), .value(value),
        .raddr_a(raddr_a), .out_a(out_a0), .raddr_b(raddr_b), .out_b(out_b0),
        .clear(clear), .busy(busy0), .save_drop(drop0)
    );

    memory_bank #(
        .WIDTH(8), .DEPTH(6), .INIT_VALUE(8'h5A), .CLEAR_VALUE(8'hC3)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .save(save), .waddr(waddr), .value(value),
        .raddr_a(raddr_a), .out_a(out_a1), .raddr_b(raddr_b), .out_b(out_b1),
        .clear(clear), .busy(busy1), .save_drop(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: an array per instance, a sweep index that runs
    // through 0..DEPTH-1 once per clear, and read results taken from the
    // array after that edge's updates.
    // ------------------------------------------------------------------
    int         dep   [2] = '{8, 6};
    logic [7:0] initv [2] = '{8'h00, 8'h5A};
    logic [7:0] clrv  [2] = '{8'h00, 8'hC3};
    logic [7:0] m_mem [2][8];
    logic [7:0] m_oa  [2];
    logic [7:0] m_ob  [2];
    bit         m_busy[2];
    int         m_idx [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int e = 0; e < 8; e++) m_mem[k][e] = initv[k];
                m_oa[k] = 8'h00;
                m_ob[k] = 8'h00;
                m_busy[k] = 1'b0;
                m_idx[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (save && !m_busy[k] && (int'(waddr) < dep[k]))
                    m_mem[k][waddr] = value;
                if (m_busy[k]) begin
                    m_mem[k][m_idx[k]] = clrv[k];
                    m_idx[k] = m_idx[k] + 1;
                    if (m_idx[k] == dep[k]) begin
                        m_busy[k] = 1'b0;
                        m_idx[k] = 0;
                    end
                end else if (clear) begin
                    m_busy[k] = 1'b1;
                    m_idx[k] = 0;
                end
                m_oa[k] = (int'(raddr_a) < dep[k]) ? m_mem[k][raddr_a] : 8'h00;
                m_ob[k] = (int'(raddr_b) < dep[k]) ? m_mem[k][raddr_b] : 8'h00;
            end
        end
    end

    // Compare process: outputs sampled on the falling edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("u0_out_a", out_a0, m_oa[0]);
            chk("u0_out_b", out_b0, m_ob[0]);
            chk("u0_busy", busy0, m_busy[0]);
            chk("u0_save_drop", drop0, save && (m_busy[0] || int'(waddr) >= dep[0]));
            chk("u1_out_a", out_a1, m_oa[1]);
            chk("u1_out_b", out_b1, m_ob[1]);
            chk("u1_busy", busy1, m_busy[1]);
            chk("u1_save_drop", drop1, save && (m_busy[1] || int'(waddr) >= dep[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int cnt;
        cnt = 0;
        while ((busy0 || busy1) && cnt < 20) begin
            cnt++;
            step();
        end
        if (busy0 || busy1) chk(name, 32'(busy0), 32'd0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b1;
        save = 1'b0; waddr = '0; value = '0; raddr_a = '0; raddr_b = '0; clear = 1'b0;
        #1 rst_n = 1'b0;
        #1 checking = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_a", out_a0, 8'h00);
        chk("rst_busy", busy0, 1'b0);
        rst_n = 1'b1;

        // Single write then read back; other entries still at init.
        save = 1'b1; waddr = 3'd3; value = 8'hA5; raddr_a = 3'd3; raddr_b = 3'd0;
        step();
        save = 1'b0;
        step();
        chk("t1_out_a", out_a0, 8'hA5);
        chk("t1_u1_out_b_init", out_b1, 8'h5A);
        for (int i = 0; i < 8; i++) begin
            raddr_b = 3'(i);
            step();
            chk("t1_entry", out_b0, (i == 3) ? 8'hA5 : 8'h00);
        end

        // Hold with save low and value toggling.
        save = 1'b1; waddr = 3'd1; value = 8'h3C; raddr_a = 3'd1;
        step();
        save = 1'b0;
        for (int i = 0; i < 10; i++) begin
            value = ~value;
            step();
            chk("t2_drop", drop0, 1'b0);
        end
        chk("t2_hold", out_a0, 8'h3C);

        // Write-first forwarding on both ports.
        save = 1'b1; waddr = 3'd2; value = 8'h11;
        step();
        value = 8'h22; raddr_a = 3'd2; raddr_b = 3'd2;
        step();
        save = 1'b0;
        chk("t3_fwd_a", out_a0, 8'h22);
        chk("t3_fwd_b", out_b0, 8'h22);

        // Fill, then sweep; busy must last exactly 8 cycles.
        for (int i = 0; i < 8; i++) begin
            save = 1'b1; waddr = 3'(i); value = 8'(8'h80 + i);
            step();
        end
        save = 1'b0; raddr_a = 3'd0; raddr_b = 3'd7;
        clear = 1'b1;
        step();
        clear = 1'b0;
        cnt = 0;
        while (busy0 && cnt < 20) begin
            cnt++;
            raddr_a = 3'(cnt);
            step();
        end
        chk("t4_busy_cycles", 32'(cnt), 32'd8);
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i);
            step();
            chk("t4_cleared", out_a0, 8'h00);
        end

        // Save during sweep is dropped; same write succeeds after.
        save = 1'b1; waddr = 3'd5; value = 8'h55;
        step();
        save = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
        save = 1'b1; waddr = 3'd5; value = 8'hFF;
        #1 chk("t5_drop_busy", drop0, 1'b1);
        step();
        save = 1'b0;
        wait_idle("t5_idle_timeout");
        raddr_a = 3'd5;
        step();
        chk("t5_mem5_cleared", out_a0, 8'h00);
        save = 1'b1; waddr = 3'd5; value = 8'hFF;
        #1 chk("t5_drop_idle", drop0, 1'b0);
        step();
        save = 1'b0;
        chk("t5_write_after", out_a0, 8'hFF);

        // Asynchronous reset mid-sweep.
        raddr_a = 3'd0; raddr_b = 3'd3;
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy_async", busy0, 1'b0);
        chk("t6_out_a_async", out_a0, 8'h00);
        chk("t6_out_b_async", out_b0, 8'h00);
        chk("t6_u1_busy_async", busy1, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("t6_u1_init", out_a1, 8'h5A);
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        chk("t6_u1_ptr0_first", out_a1, 8'hC3);
        chk("t6_u1_entry3_old", out_b1, 8'h5A);
        wait_idle("t6_idle_timeout");

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            save    = 1'($urandom_range(0, 1));
            waddr   = 3'($urandom_range(0, 7));
            value   = 8'($urandom);
            raddr_a = 3'($urandom_range(0, 7));
            raddr_b = 3'($urandom_range(0, 7));
            clear   = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        save = 1'b0; clear = 1'b0;
        repeat (2) step();

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
